// File: rtl/bf_pkg.sv
// Shared opcode and FSM state types for the Brainfuck-style tape memory.
// Opcode encodings are fixed by the command interface.
package bf_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_INC   = 3'd1,
        OP_DEC   = 3'd2,
        OP_RIGHT = 3'd3,
        OP_LEFT  = 3'd4,
        OP_WRITE = 3'd5,
        OP_CLEAR = 3'd6,
        OP_RSVD  = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        SWEEP = 2'd0,
        IDLE  = 2'd1,
        LOAD  = 2'd2
    } state_t;

endpackage

// File: rtl/bf_tape_ram.sv
// Tape storage: one synchronous write port and one registered read port.
// The array carries no reset; the controller's clear sweep zeroes it.
module bf_tape_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024,
    parameter int ADR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/bf_tape_memory.sv
// Tape memory with a cached current cell: INC/DEC/WRITE act on the cache,
// moves spill the cache to RAM and reload the neighbour, CLEAR zeroes the tape.
module bf_tape_memory
    import bf_pkg::*;
#(
    parameter int  DATA_W = 8,
    parameter int  DEPTH  = 1024,
    localparam int ADR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] word_in,
    output logic              cmd_ready,
    output logic [DATA_W-1:0] word_out,
    output logic [ADR_W-1:0]  ADR,
    output logic              is_zero,
    output logic              busy
);

    localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(DEPTH - 1);

    state_t            state_reg, state_next;
    logic [ADR_W-1:0]  cnt_reg, cnt_next;
    logic [ADR_W-1:0]  adr_reg, adr_next;
    logic [DATA_W-1:0] cur_reg, cur_next;

    logic              ram_we;
    logic [ADR_W-1:0]  ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [ADR_W-1:0]  ram_raddr;
    logic [DATA_W-1:0] ram_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= SWEEP;
            cnt_reg   <= '0;
            adr_reg   <= '0;
            cur_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            adr_reg   <= adr_next;
            cur_reg   <= cur_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        adr_next   = adr_reg;
        cur_next   = cur_reg;
        ram_we     = 1'b0;
        ram_waddr  = adr_reg;
        ram_wdata  = cur_reg;
        ram_raddr  = adr_reg;

        case (state_reg)
            SWEEP: begin
                ram_we    = 1'b1;
                ram_waddr = cnt_reg;
                ram_wdata = '0;
                if (cnt_reg == LAST_ADR) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    adr_next   = '0;
                    cur_next   = '0;
                end else begin
                    cnt_next = cnt_reg + ADR_W'(1);
                end
            end

            IDLE: begin
                if (cmd_valid) begin
                    case (op_t'(cmd_op))
                        OP_INC:   cur_next = cur_reg + DATA_W'(1);
                        OP_DEC:   cur_next = cur_reg - DATA_W'(1);
                        OP_WRITE: cur_next = word_in;
                        OP_RIGHT: begin
                            // Spill the cached cell and prefetch the new one; the
                            // two addresses always differ, so no RAM hazard.
                            ram_we     = 1'b1;
                            adr_next   = (adr_reg == LAST_ADR) ? '0 : adr_reg + ADR_W'(1);
                            ram_raddr  = adr_next;
                            state_next = LOAD;
                        end
                        OP_LEFT: begin
                            ram_we     = 1'b1;
                            adr_next   = (adr_reg == '0) ? LAST_ADR : adr_reg - ADR_W'(1);
                            ram_raddr  = adr_next;
                            state_next = LOAD;
                        end
                        OP_CLEAR: begin
                            state_next = SWEEP;
                            cnt_next   = '0;
                        end
                        default: ;
                    endcase
                end
            end

            LOAD: begin
                cur_next   = ram_rdata;
                state_next = IDLE;
            end

            default: begin
                state_next = SWEEP;
                cnt_next   = '0;
            end
        endcase
    end

    bf_tape_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADR_W  (ADR_W)
    ) u_ram (
        .clk    (clk),
        .we     (ram_we),
        .waddr  (ram_waddr),
        .wdata  (ram_wdata),
        .raddr  (ram_raddr),
        .rdata  (ram_rdata)
    );

    assign cmd_ready = (state_reg == IDLE);
    assign busy      = (state_reg == SWEEP);
    assign word_out  = cur_reg;
    assign ADR       = adr_reg;
    assign is_zero   = (cur_reg == '0);

endmodule
